// File: rtl/bank_addr_xbar.sv
// Pipelined NB-lane bank address crossbar (gather / scatter) with permutation
// checking, a sticky error flag and a saturating error counter.
module bank_addr_xbar #(
    parameter  int NB     = 4,
    parameter  int AW     = 7,
    parameter  int STAGES = 1,
    localparam int SW     = $clog2(NB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             dir,
    input  logic [NB*AW-1:0] b_in,
    input  logic [NB*SW-1:0] sel_in,
    input  logic             hold,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [NB*AW-1:0] addr_out,
    output logic             perm_err,
    output logic             err_sticky,
    output logic [7:0]       err_cnt
);

    logic [AW-1:0]    w_b     [NB];
    logic [SW-1:0]    w_sel   [NB];
    logic [AW-1:0]    w_route [NB];
    logic [NB*AW-1:0] w_route_flat;
    logic [NB-1:0]    w_seen;
    logic             w_perm_ok;
    logic             w_err_ev;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_b[i]   = b_in[i*AW +: AW];
            w_sel[i] = sel_in[i*SW +: SW];
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        w_route      = '{default: '0};
        w_route_flat = '0;
        w_seen       = '0;
        if (!dir) begin
            for (int i = 0; i < NB; i++)
                w_route[i] = w_b[w_sel[i]];
        end else begin
            // Walk from the top so the lowest colliding input index is written last and wins.
            for (int i = NB - 1; i >= 0; i--)
                w_route[w_sel[i]] = w_b[i];
        end
        for (int i = 0; i < NB; i++) begin
            w_seen[w_sel[i]]          = 1'b1;
            w_route_flat[i*AW +: AW]  = w_route[i];
        end
    end

    // NB selects covering all NB values means each value appears exactly once.
    assign w_perm_ok = &w_seen;
    assign w_err_ev  = !hold && in_valid && !w_perm_ok;

    logic             r_valid [STAGES];
    logic [NB*AW-1:0] r_data  [STAGES];
    logic             r_perr  [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the stage array is a handful of flops, not a RAM, so every entry is reset to give clean outputs immediately.
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_perr[k]  <= 1'b0;
            end
        end else if (!hold) begin
            // NOTE: non-blocking assignments let each stage read the previous stage's old value, forming a real shift register.
            r_valid[0] <= in_valid;
            r_data[0]  <= in_valid ? w_route_flat : '0;
            r_perr[0]  <= in_valid && !w_perm_ok;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
                r_perr[k]  <= r_perr[k-1];
            end
        end
    end

    logic       r_err_sticky;
    logic [7:0] r_err_cnt;

    // err_clr bypasses hold; an error counted in the same cycle survives the clear as a count of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else if (err_clr) begin
            r_err_sticky <= w_err_ev;
            r_err_cnt    <= w_err_ev ? 8'd1 : 8'd0;
        end else if (w_err_ev) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_valid  = r_valid[STAGES-1];
    assign addr_out   = r_data[STAGES-1];
    assign perm_err   = r_perr[STAGES-1];
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_bank_addr_xbar.sv
// Directed bench for bank_addr_xbar: NB=4/STAGES=1, NB=4/STAGES=3 and
// NB=8/AW=10/STAGES=2 instances driven with hand-computed vectors.
module tb_bank_addr_xbar;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // Instance A: NB=4, AW=7, STAGES=1
    logic        a_in_valid, a_dir, a_hold, a_err_clr;
    logic [27:0] a_b;
    logic [7:0]  a_sel;
    logic        a_out_valid, a_perr, a_sticky;
    logic [27:0] a_addr;
    logic [7:0]  a_cnt;

    // Instance C: NB=4, AW=7, STAGES=3
    logic        c_in_valid, c_dir, c_hold, c_err_clr;
    logic [27:0] c_b;
    logic [7:0]  c_sel;
    logic        c_out_valid, c_perr, c_sticky;
    logic [27:0] c_addr;
    logic [7:0]  c_cnt;

    // Instance E: NB=8, AW=10, STAGES=2
    logic        e_in_valid, e_dir, e_hold, e_err_clr;
    logic [79:0] e_b;
    logic [23:0] e_sel;
    logic        e_out_valid, e_perr, e_sticky;
    logic [79:0] e_addr;
    logic [7:0]  e_cnt;

    bank_addr_xbar #(.NB(4), .AW(7), .STAGES(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .dir(a_dir), .b_in(a_b),
        .sel_in(a_sel), .hold(a_hold), .err_clr(a_err_clr), .out_valid(a_out_valid),
        .addr_out(a_addr), .perm_err(a_perr), .err_sticky(a_sticky), .err_cnt(a_cnt)
    );

    bank_addr_xbar #(.NB(4), .AW(7), .STAGES(3)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .dir(c_dir), .b_in(c_b),
        .sel_in(c_sel), .hold(c_hold), .err_clr(c_err_clr), .out_valid(c_out_valid),
        .addr_out(c_addr), .perm_err(c_perr), .err_sticky(c_sticky), .err_cnt(c_cnt)
    );

    bank_addr_xbar #(.NB(8), .AW(10), .STAGES(2)) u_dut_e (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .dir(e_dir), .b_in(e_b),
        .sel_in(e_sel), .hold(e_hold), .err_clr(e_err_clr), .out_valid(e_out_valid),
        .addr_out(e_addr), .perm_err(e_perr), .err_sticky(e_sticky), .err_cnt(e_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] p4a(input int l0, input int l1, input int l2, input int l3);
        return {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
    endfunction

    function automatic logic [7:0] p4s(input int l0, input int l1, input int l2, input int l3);
        return {2'(l3), 2'(l2), 2'(l1), 2'(l0)};
    endfunction

    function automatic logic [79:0] p8a(input int l0, input int l1, input int l2, input int l3,
                                        input int l4, input int l5, input int l6, input int l7);
        return {10'(l7), 10'(l6), 10'(l5), 10'(l4), 10'(l3), 10'(l2), 10'(l1), 10'(l0)};
    endfunction

    function automatic logic [23:0] p8s(input int l0, input int l1, input int l2, input int l3,
                                        input int l4, input int l5, input int l6, input int l7);
        return {3'(l7), 3'(l6), 3'(l5), 3'(l4), 3'(l3), 3'(l2), 3'(l1), 3'(l0)};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        {a_in_valid, a_dir, a_hold, a_err_clr, a_b, a_sel} = '0;
        {c_in_valid, c_dir, c_hold, c_err_clr, c_b, c_sel} = '0;
        {e_in_valid, e_dir, e_hold, e_err_clr, e_b, e_sel} = '0;
        step();
        step();

        check("rst_valid",  128'(a_out_valid), 128'(0));
        check("rst_addr",   128'(a_addr),      128'(0));
        check("rst_perr",   128'(a_perr),      128'(0));
        check("rst_sticky", 128'(a_sticky),    128'(0));
        check("rst_cnt",    128'(a_cnt),       128'(0));
        check("rst_c_valid", 128'(c_out_valid), 128'(0));
        rst = 1'b1;

        // Gather with a reversing permutation.
        a_in_valid = 1'b1;
        a_dir = 1'b0;
        a_b   = p4a(10, 20, 30, 40);
        a_sel = p4s(3, 2, 1, 0);
        step();
        check("gather_valid", 128'(a_out_valid), 128'(1));
        check("gather_addr",  128'(a_addr),      128'(p4a(40, 30, 20, 10)));
        check("gather_perr",  128'(a_perr),      128'(0));

        // Scatter with a rotate permutation.
        a_dir = 1'b1;
        a_sel = p4s(1, 2, 3, 0);
        step();
        check("scatter_addr", 128'(a_addr), 128'(p4a(40, 10, 20, 30)));
        check("scatter_perr", 128'(a_perr), 128'(0));
        check("scatter_cnt",  128'(a_cnt),  128'(0));

        // Scatter collision: lowest input wins, untargeted lanes are 0.
        a_sel = p4s(2, 2, 0, 0);
        step();
        check("coll_addr",   128'(a_addr),   128'(p4a(30, 0, 10, 0)));
        check("coll_perr",   128'(a_perr),   128'(1));
        check("coll_cnt",    128'(a_cnt),    128'(1));
        check("coll_sticky", 128'(a_sticky), 128'(1));

        // Gather with duplicate selects still routes every lane.
        a_dir = 1'b0;
        a_sel = p4s(0, 0, 3, 3);
        step();
        check("gdup_addr", 128'(a_addr), 128'(p4a(10, 10, 40, 40)));
        check("gdup_perr", 128'(a_perr), 128'(1));
        check("gdup_cnt",  128'(a_cnt),  128'(2));

        // Invalid beat with a bad select: zero data, no error counted.
        a_in_valid = 1'b0;
        step();
        check("idle_valid", 128'(a_out_valid), 128'(0));
        check("idle_addr",  128'(a_addr),      128'(0));
        check("idle_perr",  128'(a_perr),      128'(0));
        check("idle_cnt",   128'(a_cnt),       128'(2));

        // Hold drops erroneous beats and freezes outputs and counters.
        a_in_valid = 1'b1;
        a_hold = 1'b1;
        a_dir  = 1'b1;
        a_b    = p4a(1, 2, 3, 4);
        a_sel  = p4s(2, 2, 0, 0);
        step();
        step();
        check("hold_valid", 128'(a_out_valid), 128'(0));
        check("hold_addr",  128'(a_addr),      128'(0));
        check("hold_cnt",   128'(a_cnt),       128'(2));

        // 300 erroneous beats saturate the counter.
        a_hold = 1'b0;
        repeat (300) step();
        check("sat_cnt",    128'(a_cnt),    128'(255));
        check("sat_sticky", 128'(a_sticky), 128'(1));
        check("sat_addr",   128'(a_addr),   128'(p4a(3, 0, 1, 0)));

        a_in_valid = 1'b0;
        a_err_clr  = 1'b1;
        step();
        check("clr_cnt",    128'(a_cnt),    128'(0));
        check("clr_sticky", 128'(a_sticky), 128'(0));

        // Clear coinciding with a counted error leaves a count of one.
        a_in_valid = 1'b1;
        step();
        check("clr_err_cnt",    128'(a_cnt),    128'(1));
        check("clr_err_sticky", 128'(a_sticky), 128'(1));

        // Clear is honoured during hold; the held error beat is not counted.
        a_hold = 1'b1;
        step();
        check("clr_hold_cnt",    128'(a_cnt),       128'(0));
        check("clr_hold_sticky", 128'(a_sticky),    128'(0));
        check("clr_hold_perr",   128'(a_perr),      128'(1));
        check("clr_hold_valid",  128'(a_out_valid), 128'(1));

        // Asynchronous reset mid-stream.
        a_hold    = 1'b0;
        a_err_clr = 1'b0;
        step();
        check("pre_rst_cnt", 128'(a_cnt), 128'(1));
        rst = 1'b0;
        #2;
        check("mrst_valid", 128'(a_out_valid), 128'(0));
        check("mrst_addr",  128'(a_addr),      128'(0));
        check("mrst_perr",  128'(a_perr),      128'(0));
        check("mrst_cnt",   128'(a_cnt),       128'(0));
        @(posedge clk);
        #1;
        rst   = 1'b1;
        a_dir = 1'b0;
        a_b   = p4a(10, 20, 30, 40);
        a_sel = p4s(3, 2, 1, 0);
        step();
        check("post_rst_valid", 128'(a_out_valid), 128'(1));
        check("post_rst_addr",  128'(a_addr),      128'(p4a(40, 30, 20, 10)));
        check("post_rst_cnt",   128'(a_cnt),       128'(0));
        a_in_valid = 1'b0;

        // STAGES=3 stream P, A, B(bad sel), hold 2 cycles, then C'.
        c_in_valid = 1'b1;
        c_dir = 1'b0;
        c_sel = p4s(0, 1, 2, 3);
        c_b   = p4a(1, 2, 3, 4);
        step();
        c_b   = p4a(5, 6, 7, 8);
        step();
        c_b   = p4a(11, 12, 13, 14);
        c_sel = p4s(1, 1, 2, 3);
        step();
        check("s3_p_addr", 128'(c_addr),      128'(p4a(1, 2, 3, 4)));
        check("s3_p_valid", 128'(c_out_valid), 128'(1));
        check("s3_p_perr", 128'(c_perr),      128'(0));
        check("s3_early_cnt", 128'(c_cnt),    128'(1));
        check("s3_early_sticky", 128'(c_sticky), 128'(1));

        c_hold = 1'b1;
        c_sel  = p4s(0, 1, 2, 3);
        c_b    = p4a(21, 22, 23, 24);
        step();
        check("s3_hold1_addr", 128'(c_addr), 128'(p4a(1, 2, 3, 4)));
        check("s3_hold1_cnt",  128'(c_cnt),  128'(1));
        c_b    = p4a(31, 32, 33, 34);
        step();
        check("s3_hold2_addr",  128'(c_addr),      128'(p4a(1, 2, 3, 4)));
        check("s3_hold2_valid", 128'(c_out_valid), 128'(1));

        c_hold = 1'b0;
        c_b    = p4a(41, 42, 43, 44);
        step();
        check("s3_a_addr", 128'(c_addr), 128'(p4a(5, 6, 7, 8)));
        check("s3_a_perr", 128'(c_perr), 128'(0));
        c_in_valid = 1'b0;
        step();
        check("s3_b_addr",  128'(c_addr),      128'(p4a(12, 12, 13, 14)));
        check("s3_b_perr",  128'(c_perr),      128'(1));
        check("s3_b_valid", 128'(c_out_valid), 128'(1));
        step();
        check("s3_c_addr",  128'(c_addr),      128'(p4a(41, 42, 43, 44)));
        check("s3_c_valid", 128'(c_out_valid), 128'(1));
        check("s3_c_perr",  128'(c_perr),      128'(0));
        check("s3_c_cnt",   128'(c_cnt),       128'(1));
        step();
        check("s3_end_valid", 128'(c_out_valid), 128'(0));

        // NB=8: gather by p, then scatter by p restores the original lanes.
        e_in_valid = 1'b1;
        e_dir = 1'b0;
        e_b   = p8a(101, 202, 303, 404, 505, 606, 707, 808);
        e_sel = p8s(3, 6, 0, 7, 1, 5, 2, 4);
        step();
        e_in_valid = 1'b0;
        check("nb8_latency_valid", 128'(e_out_valid), 128'(0));
        step();
        check("nb8_g_valid", 128'(e_out_valid), 128'(1));
        check("nb8_g_addr",  128'(e_addr), 128'(p8a(404, 707, 101, 808, 202, 606, 303, 505)));
        check("nb8_g_perr",  128'(e_perr), 128'(0));

        e_in_valid = 1'b1;
        e_dir = 1'b1;
        e_b   = p8a(404, 707, 101, 808, 202, 606, 303, 505);
        step();
        e_in_valid = 1'b0;
        step();
        check("nb8_s_addr", 128'(e_addr), 128'(p8a(101, 202, 303, 404, 505, 606, 707, 808)));
        check("nb8_s_perr", 128'(e_perr), 128'(0));
        check("nb8_cnt",    128'(e_cnt),  128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
